// File: rtl/s_axi_stream_arbiter.sv
// ============================================================================
// Module   : s_axi_stream_arbiter
// Purpose  : Packet-level round-robin merge of NPORTS AXI-stream slaves onto
//            one registered AXI-stream master.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module s_axi_stream_arbiter #(
  parameter int DWIDTH = 32,
  parameter int NPORTS = 2,
  parameter int IDXW   = 1
) (
  input  logic                       clk,
  input  logic                       xrst,
  input  logic [NPORTS-1:0]          port_en,
  input  logic [NPORTS-1:0]          s_tvalid,
  input  logic [NPORTS*DWIDTH-1:0]   s_tdata,
  input  logic [NPORTS*DWIDTH/8-1:0] s_tstrb,
  input  logic [NPORTS-1:0]          s_tlast,
  output logic [NPORTS-1:0]          s_tready,
  output logic                       m_tvalid,
  output logic [DWIDTH-1:0]          m_tdata,
  output logic [DWIDTH/8-1:0]        m_tstrb,
  output logic                       m_tlast,
  input  logic                       m_tready,
  output logic                       grant_valid,
  output logic [IDXW-1:0]            grant_idx
);

  localparam int c_strbw = DWIDTH / 8;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [IDXW-1:0]     r_grant;
  logic [IDXW-1:0]     r_last;
  logic [IDXW-1:0]     w_pick_idx;
  logic                w_pick_found;
  logic [NPORTS-1:0]   w_req;
  int                  w_dist;
  int                  w_best_dist;

  logic                w_out_free;
  logic                w_accept;
  logic [DWIDTH-1:0]   w_sel_data;
  logic [c_strbw-1:0]  w_sel_strb;
  logic                w_sel_last;

  logic                r_m_tvalid;
  logic [DWIDTH-1:0]   r_m_tdata;
  logic [c_strbw-1:0]  r_m_tstrb;
  logic                r_m_tlast;

  // Round-robin: the winner is the requester closest after r_last.
  always_comb begin
    w_req        = s_tvalid & port_en;
    w_pick_found = 1'b0;
    w_pick_idx   = '0;
    w_dist       = 0;
    w_best_dist  = NPORTS;
    for (int i = 0; i < NPORTS; i++) begin
      w_dist = (i - int'(r_last) - 1 + NPORTS) % NPORTS;
      if (w_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist  = w_dist;
        w_pick_idx   = IDXW'(i);
        w_pick_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_data = '0;
    w_sel_strb = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NPORTS; i++) begin
      if (r_grant == IDXW'(i)) begin
        w_sel_data = s_tdata[i*DWIDTH +: DWIDTH];
        w_sel_strb = s_tstrb[i*c_strbw +: c_strbw];
        w_sel_last = s_tlast[i];
      end
    end
  end

  assign w_out_free = !r_m_tvalid || m_tready;

  generate
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_ready
      assign s_tready[gi] = (r_state == S_GRANT) && (r_grant == IDXW'(gi)) && w_out_free;
    end
  endgenerate

  assign w_accept = |(s_tvalid & s_tready);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_found) begin
          w_next_state = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_accept && w_sel_last) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_last  <= IDXW'(NPORTS - 1);
    end else begin
      r_state <= w_next_state;
      if ((r_state == S_IDLE) && w_pick_found) begin
        r_grant <= w_pick_idx;
      end
      if ((r_state == S_GRANT) && w_accept && w_sel_last) begin
        r_last <= r_grant;
      end
    end
  end

  // Output stage: hold the beat until downstream takes it.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tstrb  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_accept) begin
      r_m_tvalid <= 1'b1;
      r_m_tdata  <= w_sel_data;
      r_m_tstrb  <= w_sel_strb;
      r_m_tlast  <= w_sel_last;
    end else if (m_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign m_tvalid    = r_m_tvalid;
  assign m_tdata     = r_m_tdata;
  assign m_tstrb     = r_m_tstrb;
  assign m_tlast     = r_m_tlast;
  assign grant_valid = (r_state == S_GRANT);
  assign grant_idx   = r_grant;

endmodule

`default_nettype wire

// File: doc/s_axi_stream_arbiter.md
Name: s_axi_stream_arbiter

Overview:
- Packet-level round-robin arbiter that merges NPORTS AXI-stream slave inputs onto one AXI-stream master output.
- The output feeds the stream-to-buffer write stage.
- Grant is locked from the first beat of a packet until the beat carrying tlast is accepted.
- Per-port enable mask lets control logic exclude requesters.

Parameters:
- DWIDTH, 32, stream data width in bits; multiple of 8.
- NPORTS, 2, number of slave inputs; 2..8.
- IDXW, 1, grant index width; 2**IDXW >= NPORTS required.

Ports:
- clk  input  1  clock.
- xrst  input  1  asynchronous active-low reset.
- port_en  input  NPORTS  per-port arbitration enable.
- s_tvalid  input  NPORTS  per-port valid.
- s_tdata  input  NPORTS*DWIDTH  port i occupies bits [i*DWIDTH +: DWIDTH].
- s_tstrb  input  NPORTS*DWIDTH/8  port i occupies bits [i*DWIDTH/8 +: DWIDTH/8].
- s_tlast  input  NPORTS  per-port end of packet.
- s_tready  output  NPORTS  per-port ready.
- m_tvalid  output  1  output valid, registered.
- m_tdata  output  DWIDTH  output data, registered.
- m_tstrb  output  DWIDTH/8  output strobe, registered.
- m_tlast  output  1  output end of packet, registered.
- m_tready  input  1  downstream ready.
- grant_valid  output  1  high while a port holds the grant.
- grant_idx  output  IDXW  index of the granted port.

Behaviour:
- Reset (async, xrst=0):
  - Registers: state=S_IDLE, r_grant=0, r_last=NPORTS-1 (so port 0 wins first), r_m_tvalid=0, m_tdata/m_tstrb/m_tlast=0.
  - Outputs: s_tready=0, grant_valid=0.
  - Reset mid-packet discards the in-flight beat and the grant; no recovery of the partial packet.
- States:
  - S_IDLE: if any bit of (s_tvalid & port_en) is set, choose the first requesting index scanning r_last+1, r_last+2, ... modulo NPORTS. Load r_grant with it and go to S_GRANT. Otherwise stay in S_IDLE.
  - S_GRANT: stay until a beat is accepted from the granted port with its s_tlast=1. Then set r_last=r_grant and go to S_IDLE.
- Arbitration costs one cycle per packet: the first beat is accepted no earlier than the cycle after the grant is taken.
- Ready (combinational): s_tready[i] = (state==S_GRANT) && (r_grant==i) && (!r_m_tvalid || m_tready). Ready on all non-granted ports is 0.
- Accept on port i means s_tvalid[i] && s_tready[i].
- Output register:
  - On accept: load m_tdata/m_tstrb/m_tlast from port r_grant and set r_m_tvalid=1.
  - Otherwise, if m_tready, clear r_m_tvalid.
  - Data is held stable while m_tvalid=1 and m_tready=0.
  - Latency from accept to m_tvalid is 1 cycle. Throughput is 1 beat/cycle while m_tready=1.
- grant_valid = (state==S_GRANT); grant_idx = r_grant.
- port_en:
  - Sampled only in S_IDLE.
  - Deasserting port_en of the granted port mid-packet does not abort; the packet completes.
  - If port_en=0 on all ports, no grant is ever taken.
- Simultaneous events:
  - Accept of the tlast beat and downstream m_tready in the same cycle are both honoured.
  - The state returns to S_IDLE the next cycle, and s_tready drops that cycle.
- Requests that drop s_tvalid before being granted are simply not selected.
- Output stays AXI-compliant: m_tvalid never drops without m_tready.

Test Plan:
- Single port, port0 sends a 3-beat packet (0xA0,0xA1,0xA2 with tlast) with m_tready=1. Required: grant_idx=0, m_tdata sequence A0,A1,A2, m_tlast only on A2, and S_IDLE in the cycle after the last accept.
- Both ports send 2-beat packets continuously from reset. Required: grants alternate 0,1,0,1, packets are never interleaved, and exactly one idle bubble separates packets.
- Backpressure: hold m_tready=0 for 4 cycles mid-packet. Required: m_tdata held, s_tready[grant]=0 during the stall, and no beat lost or duplicated.
- port_en=2'b10 while both request. Required: only port1 is granted. Drop port_en[1] mid-packet; the packet still completes with tlast.
- Assert xrst=0 in the middle of a port1 packet. Required: m_tvalid=0, s_tready=0, grant_valid=0 immediately. After release, port0 wins first.
- Release s_tvalid on port0 before its grant while port1 requests. Required: port1 is granted and no beat is taken from port0.
